// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants for the BCD clock counters (seconds, minutes, hours).
//   MOD_SEC / MOD_MIN / MOD_HOUR : counting moduli for each clock field
//   HW_60 / HW_24                : tens-digit widths for mod-60 and mod-24
//   BCD_W                        : width of one BCD digit
// tens_fits() tells whether a tens digit of width hw can hold (mod-1)/10.
// ---------------------------------------------------------------------------
package clock_pkg;

  localparam int MOD_SEC  = 60;
  localparam int MOD_MIN  = 60;
  localparam int MOD_HOUR = 24;
  localparam int HW_60    = 3;
  localparam int HW_24    = 2;
  localparam int BCD_W    = 4;

  function automatic bit tens_fits(input int hw, input int modulus);
    return (hw >= 1) && (((modulus - 1) / 10) < (1 << hw));
  endfunction

endpackage

// File: rtl/bcd_modcnt.sv
// ---------------------------------------------------------------------------
// bcd_modcnt
// Two-digit BCD modulo counter (0..MOD-1) with clear, preset and up/down
// stepping. Carry/borrow are combinational so they can drive the INC/DEC of
// a following instance in the same cycle (minutes -> hours chaining).
//
// Ports
//   CLK   in   rising-edge clock
//   RST   in   synchronous active-high reset (count and LDERR to zero)
//   CLR   in   synchronous clear of count and LDERR
//   INC   in   step up one per cycle (ignored when DEC is also high)
//   DEC   in   step down one per cycle (ignored when INC is also high)
//   LOAD  in   preset the count from LDH/LDL if the value is legal
//   LDH   in   tens digit to preset
//   LDL   in   units digit to preset
//   QH    out  tens digit (registered)
//   QL    out  units digit (registered)
//   CO    out  carry, high when this cycle's up step wraps MOD-1 -> 0
//   BO    out  borrow, high when this cycle's down step wraps 0 -> MOD-1
//   LDERR out  sticky flag, set by a rejected preset
//
// Priority each cycle: RST > CLR > LOAD > INC/DEC.
// ---------------------------------------------------------------------------
module bcd_modcnt
  import clock_pkg::*;
#(
  parameter int MOD = MOD_MIN,
  parameter int HW  = HW_60
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             INC,
  input  logic             DEC,
  input  logic             LOAD,
  input  logic [HW-1:0]    LDH,
  input  logic [BCD_W-1:0] LDL,
  output logic [HW-1:0]    QH,
  output logic [BCD_W-1:0] QL,
  output logic             CO,
  output logic             BO,
  output logic             LDERR
);

  localparam int               MAXV = MOD - 1;
  localparam logic [HW-1:0]    MAXH = HW'(MAXV / 10);
  localparam logic [BCD_W-1:0] MAXL = BCD_W'(MAXV % 10);
  localparam logic [BCD_W-1:0] NINE = BCD_W'(9);
  // Wide enough for 10*LDH + LDL at any LDH value, so the legality test
  // cannot overflow.
  localparam int               LW   = HW + 5;

  // Refuse to build a counter whose modulus or tens width makes no sense.
  generate
    if (MOD < 2 || MOD > 99 || !tens_fits(HW, MOD)) begin : g_bad_params
      $error("bcd_modcnt: illegal MOD/HW combination");
    end
  endgenerate

  logic [HW-1:0]    qh_nxt;
  logic [BCD_W-1:0] ql_nxt;
  logic             lderr_nxt;
  logic             up;
  logic             down;
  logic             at_max;
  logic             at_zero;
  logic [LW-1:0]    ld_val;
  logic             ld_ok;

  // All next-state and carry/borrow decisions live here. CO/BO are only
  // raised on the branch that actually performs the wrapping step, which
  // keeps them low whenever RST, CLR or LOAD takes precedence.
  always_comb begin
    qh_nxt    = QH;
    ql_nxt    = QL;
    lderr_nxt = LDERR;
    CO        = 1'b0;
    BO        = 1'b0;

    up      = INC & ~DEC;
    down    = DEC & ~INC;
    at_max  = (QH == MAXH) && (QL == MAXL);
    at_zero = (QH == '0) && (QL == '0);
    ld_val  = LW'(LDH) * LW'(10) + LW'(LDL);
    ld_ok   = (LDL <= NINE) && (ld_val <= LW'(MAXV));

    if (RST || CLR) begin
      qh_nxt    = '0;
      ql_nxt    = '0;
      lderr_nxt = 1'b0;
    end else if (LOAD) begin
      if (ld_ok) begin
        qh_nxt    = LDH;
        ql_nxt    = LDL;
        lderr_nxt = 1'b0;
      end else begin
        lderr_nxt = 1'b1;
      end
    end else if (up) begin
      CO = at_max;
      if (at_max) begin
        qh_nxt = '0;
        ql_nxt = '0;
      end else if (QL == NINE) begin
        qh_nxt = QH + HW'(1);
        ql_nxt = '0;
      end else begin
        ql_nxt = QL + BCD_W'(1);
      end
    end else if (down) begin
      BO = at_zero;
      if (at_zero) begin
        qh_nxt = MAXH;
        ql_nxt = MAXL;
      end else if (QL == '0) begin
        qh_nxt = QH - HW'(1);
        ql_nxt = NINE;
      end else begin
        ql_nxt = QL - BCD_W'(1);
      end
    end
  end

  // Single register stage for the digits and the sticky preset error.
  always_ff @(posedge CLK) begin
    QH    <= qh_nxt;
    QL    <= ql_nxt;
    LDERR <= lderr_nxt;
  end

endmodule

// File: tb/tb_bcd_modcnt.sv
// ---------------------------------------------------------------------------
// tb_bcd_modcnt
// Bench for bcd_modcnt: a mod-60 minutes instance and a mod-24 hours instance
// that can be chained (casc=1 routes minute CO/BO into hour INC/DEC).
// Expected behaviour comes from an integer-valued reference model.
// ---------------------------------------------------------------------------
module tb_bcd_modcnt;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       m_rst, m_clr, m_inc, m_dec, m_load;
  logic [2:0] m_ldh;
  logic [3:0] m_ldl;
  logic       h_rst, h_clr, h_inc, h_dec, h_load;
  logic [1:0] h_ldh;
  logic [3:0] h_ldl;
  logic       casc;

  logic [2:0] mqh;
  logic [3:0] mql;
  logic       mco, mbo, mlderr;
  logic [1:0] hqh;
  logic [3:0] hql;
  logic       hco, hbo, hlderr;
  logic       h_inc_w, h_dec_w;

  assign h_inc_w = casc ? mco : h_inc;
  assign h_dec_w = casc ? mbo : h_dec;

  bcd_modcnt #(.MOD(60), .HW(3)) u_min (
    .CLK(clk), .RST(m_rst), .CLR(m_clr), .INC(m_inc), .DEC(m_dec),
    .LOAD(m_load), .LDH(m_ldh), .LDL(m_ldl),
    .QH(mqh), .QL(mql), .CO(mco), .BO(mbo), .LDERR(mlderr)
  );

  bcd_modcnt #(.MOD(24), .HW(2)) u_hr (
    .CLK(clk), .RST(h_rst), .CLR(h_clr), .INC(h_inc_w), .DEC(h_dec_w),
    .LOAD(h_load), .LDH(h_ldh), .LDL(h_ldl),
    .QH(hqh), .QL(hql), .CO(hco), .BO(hbo), .LDERR(hlderr)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer counts plus error flags.
  int m_val = 0;
  int h_val = 0;
  bit m_err = 1'b0;
  bit h_err = 1'b0;
  bit e_mco, e_mbo, e_hco, e_hbo;
  logic a_mco, a_mbo, a_hco, a_hbo;

  // One cycle of a modulo counter described by its rules, on integer values.
  task automatic model_step(input int modulus, input int v, input bit e,
                            input bit rst, input bit clr, input bit load,
                            input int ldh, input int ldl,
                            input bit inc, input bit dec,
                            output int nv, output bit ne,
                            output bit co, output bit bo);
    nv = v; ne = e; co = 1'b0; bo = 1'b0;
    if (rst || clr) begin
      nv = 0; ne = 1'b0;
    end else if (load) begin
      if (ldl <= 9 && (10 * ldh + ldl) < modulus) begin
        nv = 10 * ldh + ldl; ne = 1'b0;
      end else begin
        ne = 1'b1;
      end
    end else if (inc && !dec) begin
      co = (v == modulus - 1);
      nv = (v + 1) % modulus;
    end else if (dec && !inc) begin
      bo = (v == 0);
      nv = (v + modulus - 1) % modulus;
    end
  endtask

  // Sample carry/borrow mid-cycle, advance both models, then clock once.
  task automatic cycle();
    int nmv, nhv;
    bit nme, nhe, hi, hd;
    #2;
    a_mco = mco; a_mbo = mbo; a_hco = hco; a_hbo = hbo;
    model_step(60, m_val, m_err, m_rst, m_clr, m_load, int'(m_ldh), int'(m_ldl),
               m_inc, m_dec, nmv, nme, e_mco, e_mbo);
    hi = casc ? e_mco : h_inc;
    hd = casc ? e_mbo : h_dec;
    model_step(24, h_val, h_err, h_rst, h_clr, h_load, int'(h_ldh), int'(h_ldl),
               hi, hd, nhv, nhe, e_hco, e_hbo);
    @(posedge clk);
    #1;
    m_val = nmv; m_err = nme; h_val = nhv; h_err = nhe;
  endtask

  task automatic idle_inputs();
    {m_rst, m_clr, m_inc, m_dec, m_load} = '0;
    {h_rst, h_clr, h_inc, h_dec, h_load} = '0;
    m_ldh = '0; m_ldl = '0; h_ldh = '0; h_ldl = '0; casc = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    m_rst = 1'b1; h_rst = 1'b1; m_inc = 1'b1; h_dec = 1'b1; m_load = 1'b1;
    m_ldh = 3'd4; m_ldl = 4'd2;
    repeat (2) begin
      cycle();
      checks++;
      if (mqh !== 3'd0 || mql !== 4'd0 || mlderr !== 1'b0 || a_mco !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_min got %0d/%0d err=%0b co=%0b want 0/0 err=0 co=0",
                 mqh, mql, mlderr, a_mco);
      end
      checks++;
      if (hqh !== 2'd0 || hql !== 4'd0 || hlderr !== 1'b0 || a_hbo !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_hr got %0d/%0d err=%0b bo=%0b want 0/0 err=0 bo=0",
                 hqh, hql, hlderr, a_hbo);
      end
    end
    idle_inputs();
  endtask

  task automatic test_count_up();
    idle_inputs();
    m_inc = 1'b1;
    for (int i = 0; i < 59; i++) begin
      cycle();
      checks++;
      if (mqh !== 3'(m_val / 10) || mql !== 4'(m_val % 10) || a_mco !== e_mco) begin
        errors++;
        $display("[TB] FAIL up_step%0d got %0d/%0d co=%0b want %0d/%0d co=%0b",
                 i, mqh, mql, a_mco, m_val / 10, m_val % 10, e_mco);
      end
    end
    checks++;
    if (mqh !== 3'd5 || mql !== 4'd9 || a_mco !== 1'b0) begin
      errors++;
      $display("[TB] FAIL up_59 got %0d/%0d co=%0b want 5/9 co=0", mqh, mql, a_mco);
    end
    cycle();
    checks++;
    if (mqh !== 3'd0 || mql !== 4'd0 || a_mco !== 1'b1) begin
      errors++;
      $display("[TB] FAIL up_wrap got %0d/%0d co=%0b want 0/0 co=1", mqh, mql, a_mco);
    end
    idle_inputs();
  endtask

  task automatic test_count_down();
    idle_inputs();
    h_dec = 1'b1;
    cycle();
    checks++;
    if (hqh !== 2'd2 || hql !== 4'd3 || a_hbo !== 1'b1) begin
      errors++;
      $display("[TB] FAIL down_wrap got %0d/%0d bo=%0b want 2/3 bo=1", hqh, hql, a_hbo);
    end
    repeat (4) begin
      cycle();
      checks++;
      if (hqh !== 2'(h_val / 10) || hql !== 4'(h_val % 10) || a_hbo !== e_hbo) begin
        errors++;
        $display("[TB] FAIL down_step got %0d/%0d bo=%0b want %0d/%0d bo=%0b",
                 hqh, hql, a_hbo, h_val / 10, h_val % 10, e_hbo);
      end
    end
    checks++;
    if (hqh !== 2'd1 || hql !== 4'd9) begin
      errors++;
      $display("[TB] FAIL down_19 got %0d/%0d want 1/9", hqh, hql);
    end
    idle_inputs();
  endtask

  task automatic test_load();
    idle_inputs();
    h_load = 1'b1; h_ldh = 2'd2; h_ldl = 4'd4; h_inc = 1'b1;
    cycle();
    checks++;
    if (hqh !== 2'd1 || hql !== 4'd9 || hlderr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load_24 got %0d/%0d err=%0b want 1/9 err=1", hqh, hql, hlderr);
    end
    h_ldh = 2'd1; h_ldl = 4'd5;
    cycle();
    checks++;
    if (hqh !== 2'd1 || hql !== 4'd5 || hlderr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_15 got %0d/%0d err=%0b want 1/5 err=0", hqh, hql, hlderr);
    end
    h_ldh = 2'd0; h_ldl = 4'd10;
    cycle();
    checks++;
    if (hqh !== 2'd1 || hql !== 4'd5 || hlderr !== 1'b1 || a_hco !== 1'b0) begin
      errors++;
      $display("[TB] FAIL load_ldl10 got %0d/%0d err=%0b co=%0b want 1/5 err=1 co=0",
               hqh, hql, hlderr, a_hco);
    end
    idle_inputs();
    cycle();
    checks++;
    if (hlderr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lderr_sticky got %0b want 1", hlderr);
    end
  endtask

  task automatic test_priority();
    idle_inputs();
    m_load = 1'b1; m_ldh = 3'd5; m_ldl = 4'd9;
    cycle();
    m_load = 1'b0; m_inc = 1'b1; m_dec = 1'b1;
    cycle();
    checks++;
    if (mqh !== 3'd5 || mql !== 4'd9 || a_mco !== 1'b0 || a_mbo !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inc_dec_hold got %0d/%0d co=%0b bo=%0b want 5/9 co=0 bo=0",
               mqh, mql, a_mco, a_mbo);
    end
    m_dec = 1'b0; m_load = 1'b1; m_ldh = 3'd3; m_ldl = 4'd0;
    cycle();
    checks++;
    if (mqh !== 3'd3 || mql !== 4'd0 || a_mco !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inc_load got %0d/%0d co=%0b want 3/0 co=0", mqh, mql, a_mco);
    end
    m_inc = 1'b0; m_ldh = 3'd6; m_ldl = 4'd0;
    cycle();
    m_ldh = 3'd5; m_ldl = 4'd9;
    cycle();
    m_ldh = 3'd7; m_ldl = 4'd1;
    cycle();
    m_load = 1'b0; m_inc = 1'b1; m_clr = 1'b1;
    cycle();
    checks++;
    if (mqh !== 3'd0 || mql !== 4'd0 || a_mco !== 1'b0 || mlderr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL inc_clr got %0d/%0d co=%0b err=%0b want 0/0 co=0 err=0",
               mqh, mql, a_mco, mlderr);
    end
    idle_inputs();
  endtask

  task automatic test_cascade();
    idle_inputs();
    m_load = 1'b1; m_ldh = 3'd5; m_ldl = 4'd9;
    h_load = 1'b1; h_ldh = 2'd2; h_ldl = 4'd3;
    cycle();
    idle_inputs();
    casc = 1'b1; m_inc = 1'b1;
    cycle();
    checks++;
    if (mqh !== 3'd0 || mql !== 4'd0 || hqh !== 2'd0 || hql !== 4'd0 ||
        a_mco !== 1'b1 || a_hco !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cascade got min %0d/%0d hr %0d/%0d co=%0b/%0b want 0/0 0/0 co=1/1",
               mqh, mql, hqh, hql, a_mco, a_hco);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    m_load = 1'b1; m_ldh = 3'd4; m_ldl = 4'd7;
    cycle();
    m_ldh = 3'd7; m_ldl = 4'd9;
    cycle();
    m_load = 1'b0; m_inc = 1'b1; m_rst = 1'b1;
    cycle();
    checks++;
    if (mqh !== 3'd0 || mql !== 4'd0 || mlderr !== 1'b0 || a_mco !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_mid got %0d/%0d err=%0b co=%0b want 0/0 err=0 co=0",
               mqh, mql, mlderr, a_mco);
    end
    m_rst = 1'b0;
    cycle();
    checks++;
    if (mqh !== 3'd0 || mql !== 4'd1 || a_mco !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_resume got %0d/%0d co=%0b want 0/1 co=0", mqh, mql, a_mco);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 600; i++) begin
      m_rst  = ($urandom_range(0, 40) == 0);
      h_rst  = ($urandom_range(0, 40) == 0);
      m_clr  = ($urandom_range(0, 25) == 0);
      h_clr  = ($urandom_range(0, 25) == 0);
      m_load = ($urandom_range(0, 7) == 0);
      h_load = ($urandom_range(0, 7) == 0);
      m_ldh  = 3'($urandom_range(0, 7));
      m_ldl  = 4'($urandom_range(0, 15));
      h_ldh  = 2'($urandom_range(0, 3));
      h_ldl  = 4'($urandom_range(0, 15));
      m_inc  = ($urandom_range(0, 2) != 0);
      m_dec  = ($urandom_range(0, 2) == 0);
      h_inc  = $urandom_range(0, 1) != 0;
      h_dec  = $urandom_range(0, 1) != 0;
      casc   = $urandom_range(0, 1) != 0;
      cycle();
      checks++;
      if (mqh !== 3'(m_val / 10) || mql !== 4'(m_val % 10) || mlderr !== m_err ||
          a_mco !== e_mco || a_mbo !== e_mbo) begin
        errors++;
        $display("[TB] FAIL rand_min%0d got %0d/%0d err=%0b co=%0b bo=%0b want %0d/%0d err=%0b co=%0b bo=%0b",
                 i, mqh, mql, mlderr, a_mco, a_mbo,
                 m_val / 10, m_val % 10, m_err, e_mco, e_mbo);
      end
      checks++;
      if (hqh !== 2'(h_val / 10) || hql !== 4'(h_val % 10) || hlderr !== h_err ||
          a_hco !== e_hco || a_hbo !== e_hbo) begin
        errors++;
        $display("[TB] FAIL rand_hr%0d got %0d/%0d err=%0b co=%0b bo=%0b want %0d/%0d err=%0b co=%0b bo=%0b",
                 i, hqh, hql, hlderr, a_hco, a_hbo,
                 h_val / 10, h_val % 10, h_err, e_hco, e_hbo);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_priority();
    test_cascade();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_modcnt.md
BCD_MODCNT -- requirements
Module: bcd_modcnt

Interface
REQ-001 Parameter MOD, default 60: count modulus, legal range 2..99; value range 0..MOD-1.
REQ-002 Parameter HW, default 3: tens-digit width; SHALL be large enough to hold (MOD-1)/10.
REQ-003 CLK  in  1  sole clock; all state updates on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CLR  in  1  synchronous clear of count and error flag.
REQ-006 INC  in  1  count-up request, one step per cycle asserted.
REQ-007 DEC  in  1  count-down request, one step per cycle asserted.
REQ-008 LOAD  in  1  preset request for the count.
REQ-009 LDH  in  HW  tens digit to preset.
REQ-010 LDL  in  4  units digit to preset.
REQ-011 QH  out  HW  tens digit, registered.
REQ-012 QL  out  4  units digit, registered.
REQ-013 CO  out  1  carry: high when this cycle's step wraps MOD-1 -> 0; combinational.
REQ-014 BO  out  1  borrow: high when this cycle's step wraps 0 -> MOD-1; combinational.
REQ-015 LDERR  out  1  sticky flag for a rejected preset, registered.

Function
REQ-016 Priority per cycle SHALL be RST > CLR > LOAD > INC/DEC.
REQ-017 CLR SHALL set QH=0, QL=0 and LDERR=0 on the next edge.
REQ-018 Effective step: up = INC & ~DEC; down = DEC & ~INC; INC&DEC together SHALL hold the count.
REQ-019 Up step: QL<9 -> QL+1; QL=9 -> QL=0, QH+1; value MOD-1 -> QH=0, QL=0.
REQ-020 Down step: QL>0 -> QL-1; QL=0 -> QL=9, QH-1; value 0 -> QH=(MOD-1)/10, QL=(MOD-1)%10.
REQ-021 CO = up & ~CLR & ~LOAD & (value==MOD-1); BO = down & ~CLR & ~LOAD & (value==0); both SHALL be low during RST.
REQ-022 A legal LOAD (LDL<=9 and 10*LDH+LDL<=MOD-1) SHALL set QH=LDH, QL=LDL and clear LDERR on the next edge.
REQ-023 An illegal LOAD SHALL leave QH/QL unchanged and set LDERR=1, held until CLR, RST, or a legal LOAD.
REQ-024 INC/DEC coincident with LOAD SHALL be ignored, and no CO/BO SHALL be issued.
REQ-025 QH/QL SHALL never leave 0..MOD-1 and QL SHALL never exceed 9.
REQ-026 CO/BO SHALL be usable as INC/DEC of a cascaded instance in the same cycle (minute -> hour chaining).

Reset
REQ-027 While RST=1, on each edge: QH=0, QL=0, LDERR=0; all other inputs ignored.
REQ-028 RST asserted mid-count SHALL take effect on the next edge, with no residual carry/borrow afterward.

Structure
REQ-029 Shared package clock_pkg SHALL hold constants MOD_SEC=60, MOD_MIN=60, MOD_HOUR=24, HW_60=3, HW_24=2, and the BCD digit width 4.
REQ-030 Single module; no sub-module; next-value logic kept in one combinational block feeding one register block.
REQ-031 Elaboration SHALL fail if MOD is outside 2..99 or HW is too narrow.

Verification
REQ-032 MOD=60: RST, then INC for 59 cycles -> 5/9 and CO=0; one more INC -> CO=1 that cycle, then 0/0.
REQ-033 MOD=24: from 0/0 apply DEC -> BO=1, then 2/3; DEC four more times -> 1/9.
REQ-034 MOD=24: LOAD LDH=2, LDL=4 -> count unchanged, LDERR=1; LOAD 1/5 -> 1/5, LDERR=0; LOAD LDL=10 -> LDERR=1.
REQ-035 MOD=60: at 5/9 drive INC=DEC=1 -> hold, CO=0; INC with LOAD 3/0 -> 3/0, CO=0; INC with CLR -> 0/0, CO=0.
REQ-036 Cascade MOD=60 into MOD=24: at minutes 5/9, hours 2/3, one INC -> both 0/0 on the same edge.
REQ-037 RST mid-count at 4/7 with INC held -> 0/0 next edge, LDERR=0; counting resumes 0/1 after RST drops.
